// File: rtl/unidade_controle_rodadas.sv
// Round-based memory game control unit.
// Moore FSM with per-play timeout and debug state code.
module unidade_controle_rodadas #(
  parameter int TIMEOUT = 3000,
  parameter int TW      = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualLimite,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIO_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h3,
    REGISTRA       = 4'h4,
    COMPARACAO     = 4'h5,
    PROXIMO        = 4'h6,
    PROXIMA_RODADA = 4'h7,
    FIM_ACERTOU    = 4'hA,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERROU      = 4'hE
  } estado_t;

  localparam logic [TW-1:0] LIM = TW'(TIMEOUT - 1);

  estado_t       r_estado;
  estado_t       w_prox;
  logic [TW-1:0] r_tcount;
  logic          w_limite;

  assign w_limite = (r_tcount == LIM);

  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:
        w_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:
        w_prox = INICIO_RODADA;
      INICIO_RODADA:
        w_prox = ESPERA_JOGADA;
      ESPERA_JOGADA:
        if (jogada)        w_prox = REGISTRA;
        else if (w_limite) w_prox = FIM_TIMEOUT;
        else               w_prox = ESPERA_JOGADA;
      REGISTRA:
        w_prox = COMPARACAO;
      COMPARACAO:
        if (!igual)                           w_prox = FIM_ERROU;
        else if (enderecoIgualLimite && fimL) w_prox = FIM_ACERTOU;
        else if (enderecoIgualLimite)         w_prox = PROXIMA_RODADA;
        else                                  w_prox = PROXIMO;
      PROXIMO:
        w_prox = ESPERA_JOGADA;
      PROXIMA_RODADA:
        w_prox = INICIO_RODADA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT:
        w_prox = iniciar ? PREPARACAO : r_estado;
      default:
        w_prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so they line up with r_estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_tcount  <= '0;
      zeraE     <= 1'b0;
      contaE    <= 1'b0;
      zeraL     <= 1'b0;
      contaL    <= 1'b0;
      zeraR     <= 1'b0;
      registraR <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 4'h0;
    end else begin
      r_estado  <= w_prox;
      r_tcount  <= (r_estado == ESPERA_JOGADA) ?
                   r_tcount + 1'b1 : '0;
      zeraE     <= (w_prox == PREPARACAO) ||
                   (w_prox == INICIO_RODADA);
      contaE    <= (w_prox == PROXIMO);
      zeraL     <= (w_prox == PREPARACAO);
      contaL    <= (w_prox == PROXIMA_RODADA);
      zeraR     <= (w_prox == PREPARACAO);
      registraR <= (w_prox == REGISTRA);
      acertou   <= (w_prox == FIM_ACERTOU);
      errou     <= (w_prox == FIM_ERROU);
      timeout   <= (w_prox == FIM_TIMEOUT);
      pronto    <= (w_prox == FIM_ACERTOU) ||
                   (w_prox == FIM_ERROU) ||
                   (w_prox == FIM_TIMEOUT);
      db_estado <= w_prox;
    end
  end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Randomized game-level bench for unidade_controle_rodadas.
// Expected per-cycle trace is built from the game rules.
module tb_unidade_controle_rodadas;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada;
  logic       igual, enderecoIgualLimite, fimL;
  logic       zeraE, contaE, zeraL, contaL, zeraR;
  logic       registraR, acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] st;
    logic       jog;
    logic       ini;
    logic       rst;
    logic       ig;
    logic       eil;
    logic       fl;
  } ent_t;

  ent_t q[$];
  logic g_ig, g_eil, g_fl;

  unidade_controle_rodadas #(.TIMEOUT(TO), .TW(4)) dut (
    .clock(clock), .reset(reset),
    .iniciar(iniciar), .jogada(jogada),
    .igual(igual),
    .enderecoIgualLimite(enderecoIgualLimite),
    .fimL(fimL),
    .zeraE(zeraE), .contaE(contaE),
    .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR),
    .acertou(acertou), .errou(errou),
    .timeout(timeout), .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {zeraE,contaE,zeraL,contaL,zeraR,registraR,
  //  acertou,errou,timeout,pronto}
  function automatic logic [9:0] exp_out(input logic [3:0] s);
    case (s)
      4'h1:    return 10'b1010100000;
      4'h2:    return 10'b1000000000;
      4'h4:    return 10'b0000010000;
      4'h6:    return 10'b0100000000;
      4'h7:    return 10'b0001000000;
      4'hA:    return 10'b0000001001;
      4'hE:    return 10'b0000000101;
      4'hD:    return 10'b0000000011;
      default: return 10'b0;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic jog,
                      input logic ini, input logic rst);
    ent_t e;
    e.st  = st;
    e.jog = jog;
    e.ini = ini;
    e.rst = rst;
    e.ig  = g_ig;
    e.eil = g_eil;
    e.fl  = g_fl;
    q.push_back(e);
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // kind: 0 none, 1 wrong play, 2 timeout, 3 reset after proximo
  task automatic gen_game(input int nr, input int br,
                          input int bp, input int kind,
                          input int dly);
    int d;
    logic bad;
    push(4'h1, rb(), 1'b1, 1'b0);
    push(4'h2, rb(), rb(), 1'b0);
    for (int r = 0; r < nr; r++) begin
      for (int p = 0; p <= r; p++) begin
        bad   = (r == br) && (p == bp);
        g_ig  = !(bad && kind == 1);
        g_eil = (p == r);
        g_fl  = (r == nr - 1);
        d = (dly >= 0) ? dly : int'($urandom_range(0, TO - 1));
        if (bad && kind == 2) begin
          push(4'h3, rb(), rb(), 1'b0);
          for (int i = 1; i < TO; i++) push(4'h3, 1'b0, rb(), 1'b0);
          push(4'hD, 1'b0, 1'b0, 1'b0);
          return;
        end
        push(4'h3, rb(), rb(), 1'b0);
        for (int i = 0; i < d; i++) push(4'h3, 1'b0, rb(), 1'b0);
        push(4'h4, 1'b1, rb(), 1'b0);
        push(4'h5, rb(), rb(), 1'b0);
        if (!g_ig) begin
          push(4'hE, rb(), 1'b0, 1'b0);
          return;
        end else if (g_eil && g_fl) begin
          push(4'hA, rb(), 1'b0, 1'b0);
          return;
        end else if (g_eil) begin
          push(4'h7, rb(), rb(), 1'b0);
          push(4'h2, rb(), rb(), 1'b0);
        end else begin
          push(4'h6, rb(), rb(), 1'b0);
          if (bad && kind == 3) begin
            push(4'h0, rb(), rb(), 1'b1);
            return;
          end
        end
      end
    end
  endtask

  task automatic hold(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) push(st, rb(), 1'b0, 1'b0);
  endtask

  task automatic gen_random();
    int nr, br, bp, kind;
    nr   = int'($urandom_range(1, 3));
    br   = int'($urandom_range(0, nr - 1));
    bp   = int'($urandom_range(0, br));
    kind = int'($urandom_range(0, 2));
    gen_game(nr, br, bp, kind, -1);
    hold(q[$].st, 2);
  endtask

  initial begin
    ent_t e;
    g_ig = 1'b1; g_eil = 1'b0; g_fl = 1'b0;
    reset = 1'b1; iniciar = 1'b0; jogada = 1'b0;
    igual = 1'b0; enderecoIgualLimite = 1'b0; fimL = 1'b0;

    push(4'h0, 1'b0, 1'b0, 1'b1);
    hold(4'h0, 2);
    gen_game(2, 1, 0, 3, -1);
    hold(4'h0, 3);
    gen_game(2, -1, -1, 0, 1);
    hold(4'hA, 2);
    gen_game(2, 1, 1, 1, -1);
    hold(4'hE, 2);
    gen_game(1, 0, 0, 2, -1);
    hold(4'hD, 2);
    gen_game(2, -1, -1, 0, TO - 1);
    hold(4'hA, 2);
    gen_game(2, 1, 0, 2, 0);
    hold(4'hD, 1);
    for (int g = 0; g < 25; g++) gen_random();

    foreach (q[i]) begin
      e = q[i];
      reset   = e.rst;
      iniciar = e.ini;
      jogada  = e.jog;
      igual   = e.ig;
      enderecoIgualLimite = e.eil;
      fimL    = e.fl;
      @(posedge clock);
      #1;
      chk($sformatf("estado[%0d]", i),
          16'(db_estado), 16'(e.st));
      chk($sformatf("saidas[%0d]", i),
          16'({zeraE, contaE, zeraL, contaL, zeraR, registraR,
               acertou, errou, timeout, pronto}),
          16'(exp_out(e.st)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
- Moore control unit for the round-based version of the memory game: round k requires the player to repeat sequence positions 0..k.
- Sequences the game datapath through its address counter (E), round-limit counter (L) and play register (R).
- Enforces a per-play timeout with an internal counter.
- Drives game status and the state debug code shown on the state display.

Parameters:
- TIMEOUT, default 3000: clock cycles allowed in espera_jogada before timeout; legal range 2..65535.
- TW, default 16: timeout counter width; must satisfy 2^TW >= TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; forces inicial
- iniciar  in  1  start or restart request (level)
- jogada  in  1  one-cycle play pulse from datapath edge detector
- igual  in  1  registered play equals memory word at current address
- enderecoIgualLimite  in  1  address counter equals round limit
- fimL  in  1  round-limit counter at final round
- zeraE  out  1  clear address counter
- contaE  out  1  increment address counter
- zeraL  out  1  clear round-limit counter
- contaL  out  1  increment round-limit counter
- zeraR  out  1  clear play register
- registraR  out  1  load play register
- acertou  out  1  game won
- errou  out  1  wrong play
- timeout  out  1  play timed out
- pronto  out  1  game finished (any outcome)
- db_estado  out  4  current state code

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset:
  - next state is inicial regardless of the current state or inputs, including mid-round;
  - all outputs 0 except db_estado=0;
  - timeout counter = 0.
- All outputs are decoded from the state only (Moore). db_estado equals the state code.
- States, with code, asserted outputs and transitions:
  - inicial (0): no outputs. iniciar=1 -> preparacao; else stay.
  - preparacao (1): zeraE, zeraL, zeraR. -> inicio_rodada unconditionally.
  - inicio_rodada (2): zeraE. -> espera_jogada.
  - espera_jogada (3): no strobes.
    - jogada=1 -> registra.
    - Else, if tcount == TIMEOUT-1 -> fim_timeout.
    - Else stay.
    - If jogada=1 on the same cycle as the timeout limit, jogada wins.
  - registra (4): registraR. -> comparacao.
  - comparacao (5): evaluated in priority order:
    - igual=0 -> fim_errou;
    - else enderecoIgualLimite=1 and fimL=1 -> fim_acertou;
    - else enderecoIgualLimite=1 -> proxima_rodada;
    - else -> proximo.
  - proximo (6): contaE. -> espera_jogada.
  - proxima_rodada (7): contaL. -> inicio_rodada.
  - fim_acertou (A): acertou, pronto.
  - fim_errou (E): errou, pronto.
  - fim_timeout (D): timeout, pronto.
- All three final states: iniciar=1 -> preparacao; else hold.
- Unused codes (8, 9, B, C, F) -> inicial on the next clock, all outputs 0.
- Timeout counter:
  - tcount is TW bits.
  - Cleared to 0 on any clock where the current state is not espera_jogada.
  - Increments by 1 each clock spent in espera_jogada. Saturation is never needed because it exits at TIMEOUT-1.
  - Player therefore has exactly TIMEOUT cycles per play, measured from entry into espera_jogada. The counter restarts for every play.
- Latency:
  - iniciar in inicial -> zeraE/zeraL/zeraR visible 1 cycle later.
  - jogada pulse -> registraR 1 cycle later -> comparison decision on the following cycle.
  - Comparison outcome -> status output 1 cycle after comparacao.
- iniciar held high is level-sensitive: it restarts immediately from any final state. jogada is ignored outside espera_jogada.

Test Plan (bench models the datapath flags; TIMEOUT=8):
- Reset mid-game: drive to proximo (6), assert reset 1 cycle -> db_estado=0, all outputs 0; iniciar=0 keeps state 0.
- Win with 2 rounds:
  - Round limit 0: one jogada with igual=1, enderecoIgualLimite=1, fimL=0 -> states 3,4,5,7,2,3; contaL pulses once.
  - Round limit 1: two plays, enderecoIgualLimite=1 on the second and fimL=1 -> state A, acertou=1, pronto=1.
- Error: second play of round 1 with igual=0 -> state E, errou=1, pronto=1; acertou=0, timeout=0.
- Timeout exact: enter state 3, no jogada -> remains 3 for 8 cycles, then D with timeout=1, pronto=1. Repeat with jogada on cycle 8 (tcount=7) -> goes to 4, no timeout.
- Restart: in E, iniciar=1 -> state 1 with zeraE=zeraL=zeraR=1 for one cycle, then 2, then 3; tcount restarts at 0.
- Illegal state: force state code F -> next cycle 0, outputs all 0.
